key_command_queue: RTL and testbench

Parametrised keyboard-to-game command front end: sits between the PS/2 key decoder outputs and the game controller, replacing the ad-hoc fixed-priority key mux at the top level. Converts per-key level signals into discrete command events, including rising-edge presses and optional held-key auto-repeat. Buffers events in a small FIFO with a valid/ready handshake, and turns the restart key into a stretched game reset pulse that also flushes pending commands.

---
 rtl/key_command_queue_if.sv | 8 +
 rtl/key_command_queue.sv | 124 ++++++++++++
 tb/tb_key_command_queue.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/key_command_queue_if.sv
// key_command_queue_if: command handshake between the key front end and the game controller
interface key_command_queue_if #(parameter int CMD_W = 3);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CMD_W-1:0] cmd_code;
  modport master (output cmd_valid, cmd_code, input cmd_ready);
  modport slave (input cmd_valid, cmd_code, output cmd_ready);
endinterface

// File: rtl/key_command_queue.sv
// key_command_queue: key levels to queued command events with restart pulse; KEYCMD_AUTOREPEAT_EN adds held-key auto-repeat
module key_command_queue #(
  parameter int NUM_KEYS      = 5,
  parameter int CMD_W         = 3,
  parameter int CMD_BASE      = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 5_000_000,
  parameter int RST_PULSE     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_KEYS-1:0]           key_level,
  key_command_queue_if.master           cmd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          game_rst,
  output logic                          restart_toggle,
  output logic                          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(RST_PULSE + 1);
  localparam int KW = $clog2(NUM_KEYS);

  logic [NUM_KEYS-1:0] key_q, press, pending, ev, rep_ev, wr_bit;
  logic [CMD_W-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]       rd_ptr, wr_ptr;
  logic [AW:0]         count;
  logic [PW-1:0]       pulse;
  logic [KW-1:0]       wr_idx;
  logic [CMD_W-1:0]    wr_code;
  logic                restart, pop, full, wr_en;

  assign press          = key_level & ~key_q;
  assign restart        = press[0];
  assign full           = count == (AW+1)'(FIFO_DEPTH);
  assign pop            = cmd.cmd_valid & cmd.cmd_ready;
  assign cmd.cmd_valid  = count != '0;
  assign cmd.cmd_code   = cmd.cmd_valid ? mem[rd_ptr] : '0;
  assign fifo_level     = count;
  assign game_rst       = pulse != '0;
  assign ev             = game_rst ? '0 : ({press[NUM_KEYS-1:1], 1'b0} | rep_ev);
  assign wr_en          = (|pending) & (!full | pop);
  assign wr_code        = CMD_W'(CMD_BASE + int'(wr_idx) - 1);

  // Pick the lowest-index pending command key for this cycle's FIFO write
  always_comb begin
    wr_idx = '0;
    wr_bit = '0;
    for (int i = NUM_KEYS - 1; i >= 1; i--) wr_idx = pending[i] ? KW'(i) : wr_idx;
    if (wr_en) wr_bit[wr_idx] = 1'b1;
  end

`ifdef KEYCMD_AUTOREPEAT_EN
  localparam int RW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  logic          trk_on;
  logic [KW-1:0] trk_key, new_key;
  logic [RW-1:0] trk_cnt;
  logic          cmd_press;

  assign cmd_press = |press[NUM_KEYS-1:1];

  // Repeat fires when the tracked key is still held and its countdown reaches 1; newest press is the highest index pressed
  always_comb begin
    rep_ev  = '0;
    new_key = '0;
    for (int i = 1; i < NUM_KEYS; i++) new_key = press[i] ? KW'(i) : new_key;
    if (trk_on && key_level[trk_key] && trk_cnt == RW'(1)) rep_ev[trk_key] = 1'b1;
  end

  // Tracker follows the most recent command press, drops on release, restart or reset
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      trk_on  <= 1'b0;
      trk_key <= '0;
      trk_cnt <= '0;
    end else if (cmd_press && !game_rst) begin
      trk_on  <= 1'b1;
      trk_key <= new_key;
      trk_cnt <= RW'(REPEAT_DELAY);
    end else if (trk_on && !key_level[trk_key]) begin
      trk_on <= 1'b0;
    end else if (trk_on) begin
      trk_cnt <= trk_cnt == RW'(1) ? RW'(REPEAT_PERIOD) : trk_cnt - RW'(1);
    end
  end
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = |{REPEAT_DELAY, REPEAT_PERIOD};
  assign rep_ev = '0;
`endif

  // FIFO storage; stale entries are harmless because pointers reset separately
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_code;
  end

  // Pending mask, FIFO pointers, restart pulse and sticky flags; restart flushes everything queued
  always_ff @(posedge clk) begin
    key_q <= key_level;
    if (rst) begin
      pending        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      pulse          <= '0;
      overflow       <= 1'b0;
      restart_toggle <= 1'b0;
    end else if (restart) begin
      pending        <= '0;
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      pulse          <= PW'(RST_PULSE);
      restart_toggle <= ~restart_toggle;
    end else begin
      pending <= (pending & ~wr_bit) | ev;
      if (|(ev & pending & ~wr_bit)) overflow <= 1'b1;
      if (game_rst) pulse <= pulse - PW'(1);
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end
endmodule

// File: tb/tb_key_command_queue.sv
// tb_key_command_queue: queue/event-time reference model with directed and random stimulus
module tb_key_command_queue;
  localparam int NK = 5, CW = 3, CB = 4, FD = 4, RD = 10, RP = 4, RPL = 3;
  localparam int LW = $clog2(FD) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_level = '0;
  logic [LW-1:0] fifo_level;
  logic          game_rst, restart_toggle, overflow;
  int            checks = 0, failures = 0;

  key_command_queue_if #(.CMD_W(CW)) cmd ();

  key_command_queue #(
    .NUM_KEYS(NK), .CMD_W(CW), .CMD_BASE(CB), .FIFO_DEPTH(FD),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .RST_PULSE(RPL)
  ) dut (
    .clk(clk), .rst(rst), .key_level(key_level), .cmd(cmd),
    .fifo_level(fifo_level), .game_rst(game_rst),
    .restart_toggle(restart_toggle), .overflow(overflow)
  );

  always #5 clk = ~clk;

  logic [CW-1:0] mq [$];
  logic [NK-1:0] mpend = '0, mprev = '0;
  int            cyc = 0, mrst_edge = -1000, mtrk = -1, mtp = 0;
  logic          movf = 1'b0, mtog = 1'b0;

  function automatic void model_step();
    logic [NK-1:0] press, ev, wr;
    bit grst, pop;
    cyc++;
    if (rst) begin
      mq.delete(); mpend = '0; mprev = key_level; mrst_edge = -1000; mtrk = -1; movf = 0; mtog = 0;
      return;
    end
    press = key_level & ~mprev;
    mprev = key_level;
    grst = (cyc - 1 - mrst_edge) >= 0 && (cyc - 1 - mrst_edge) < RPL;
    if (press[0]) begin
      mrst_edge = cyc; mq.delete(); mpend = '0; mtrk = -1; mtog = ~mtog;
      return;
    end
    ev = '0;
    if (!grst) begin
      ev = press;
`ifdef KEYCMD_AUTOREPEAT_EN
      if (mtrk >= 0 && !key_level[mtrk]) mtrk = -1;
      if (mtrk >= 0 && cyc - mtp >= RD && (cyc - mtp - RD) % RP == 0) ev[mtrk] = 1'b1;
      for (int i = 1; i < NK; i++) if (press[i]) begin mtrk = i; mtp = cyc; end
`endif
    end
    pop = mq.size() > 0 && cmd.cmd_ready;
    wr = '0;
    for (int i = 1; i < NK; i++) if (mpend[i] && wr == '0) wr[i] = 1'b1;
    if (pop) void'(mq.pop_front());
    if (wr != '0) begin
      if (mq.size() < FD) begin
        for (int i = 1; i < NK; i++) if (wr[i]) mq.push_back(CW'(CB + i - 1));
      end else wr = '0;
    end
    if ((ev & mpend & ~wr) != '0) movf = 1'b1;
    mpend = (mpend & ~wr) | ev;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [CW-1:0] head = mq.size() != 0 ? mq[0] : CW'(0);
    bit g = (cyc - mrst_edge) >= 0 && (cyc - mrst_edge) < RPL;
    return 32'({mq.size() != 0, head, LW'(mq.size()), g, mtog, movf});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("outputs", 32'({cmd.cmd_valid, cmd.cmd_code, fifo_level, game_rst, restart_toggle, overflow}), exp_vec());
  endtask

  task automatic do_reset();
    key_level = '0; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    cmd.cmd_ready = 1'b1;
    do_reset();
    chk("reset_outputs", 32'({cmd.cmd_valid, cmd.cmd_code, fifo_level, game_rst, restart_toggle, overflow}), 0);
    // single press of key 2
    key_level = 5'b00100; tick();
    chk("single_not_yet", 32'(cmd.cmd_valid), 0);
    key_level = '0; tick();
    chk("single_code", 32'({cmd.cmd_valid, cmd.cmd_code}), 32'({1'b1, 3'd5}));
    tick();
    chk("single_drained", 32'({cmd.cmd_valid, fifo_level}), 0);
    // simultaneous presses with backpressure
    do_reset(); cmd.cmd_ready = 1'b0;
    key_level = 5'b11010; tick();
    key_level = '0; tick(); tick(); tick();
    chk("multi_level", 32'(fifo_level), 3);
    chk("multi_head0", 32'(cmd.cmd_code), 4);
    cmd.cmd_ready = 1'b1; tick();
    chk("multi_head1", 32'(cmd.cmd_code), 6);
    tick();
    chk("multi_head2", 32'(cmd.cmd_code), 7);
    tick();
    chk("multi_empty", 32'(fifo_level), 0);
    // backpressure and overflow
    do_reset(); cmd.cmd_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin key_level = 5'b00010; tick(); key_level = '0; tick(); end
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    cmd.cmd_ready = 1'b1; n = 0;
    for (int k = 0; k < 8; k++) begin if (cmd.cmd_valid) n++; tick(); end
    chk("ovf_total", 32'(n), 5);
    // held key auto-repeat
    do_reset(); n = 0;
    for (int k = 0; k < 34; k++) begin
      key_level = k < 30 ? 5'b10000 : 5'b00000;
      if (cmd.cmd_valid) n++;
      tick();
    end
`ifdef KEYCMD_AUTOREPEAT_EN
    chk("repeat_count", 32'(n), 6);
`else
    chk("repeat_count", 32'(n), 1);
`endif
    // restart flush and pulse
    do_reset(); cmd.cmd_ready = 1'b0;
    key_level = 5'b01110; tick();
    key_level = '0; tick(); tick(); tick();
    chk("restart_pre_level", 32'(fifo_level), 3);
    key_level = 5'b00001; tick();
    chk("restart_flush", 32'({fifo_level, restart_toggle}), 32'({3'd0, 1'b1}));
    key_level = 5'b00011; n = 0;
    for (int k = 0; k < 6; k++) begin if (game_rst) n++; tick(); end
    chk("restart_pulse_len", 32'(n), 3);
    for (int k = 0; k < 12; k++) tick();
    chk("restart_drop_key1", 32'(fifo_level), 0);
    // reset mid-operation with keys held
    do_reset();
    key_level = 5'b01010; tick(); tick(); tick();
    chk("midrst_pre_level", 32'(fifo_level), 2);
    rst = 1'b1; tick();
    chk("midrst_outputs", 32'({cmd.cmd_valid, cmd.cmd_code, fifo_level, game_rst, restart_toggle, overflow}), 0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 15; k++) tick();
    chk("midrst_no_cmd", 32'({cmd.cmd_valid, fifo_level}), 0);
    // randomized traffic against the model
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(1, NK - 1);
        key_level[n] = ~key_level[n];
      end
      if (key_level[0]) begin
        if ($urandom_range(0, 3) == 0) key_level[0] = 1'b0;
      end else if ($urandom_range(0, 149) == 0) key_level[0] = 1'b1;
      cmd.cmd_ready = ((k / 1000) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst = $urandom_range(0, 499) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
